cmd_dispatch: RTL

CMD_DISPATCH -- requirements
Module: cmd_dispatch

---
 rtl/cmd_dispatch.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/cmd_dispatch.sv
// Command dispatcher: routes received commands to the local register port, the
// transmit FIFO, or both, and returns local read replies through the same FIFO.

module cmd_dispatch #(
    parameter int         DW       = 8,
    parameter int         FIFO_AW  = 2,
    parameter logic [7:0] BCAST_ID = 8'hFF,
    parameter int         RD_LAT   = 2,
    parameter int         TMO_US   = 1000
) (
    input  logic          clk_sys,
    input  logic          rst,
    input  logic          pluse_us,
    input  logic [7:0]    dev_id,
    input  logic [7:0]    cmdr_dev,
    input  logic [7:0]    cmdr_mod,
    input  logic [7:0]    cmdr_addr,
    input  logic [DW-1:0] cmdr_data,
    input  logic          cmdr_vld,
    output logic [7:0]    cmdt_dev,
    output logic [7:0]    cmdt_mod,
    output logic [7:0]    cmdt_addr,
    output logic [DW-1:0] cmdt_data,
    output logic          cmdt_vld,
    input  logic          cmdt_rdy,
    output logic [15:0]   fx_waddr,
    output logic          fx_wr,
    output logic [DW-1:0] fx_data,
    output logic [15:0]   fx_raddr,
    output logic          fx_rd,
    input  logic [DW-1:0] fx_q,
    output logic [7:0]    drop_cnt,
    output logic          tx_tmo
);

    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam int          EW       = 24 + DW;
    localparam logic [2:0]  LAT_LAST = 3'(RD_LAT);
    localparam logic [15:0] TMO_LAST = 16'(TMO_US - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RD_WAIT, S_REPLY} state_t;

    state_t             r_state;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic [15:0]        r_tmo_cnt;
    logic               r_tx_tmo;
    logic               r_fx_wr;
    logic               r_fx_rd;
    logic [15:0]        r_waddr;
    logic [15:0]        r_raddr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_q;
    logic               r_hold;
    logic [2:0]         r_lat;
    logic [7:0]         r_drop;

    logic               w_empty;
    logic               w_full;
    logic               w_local;
    logic               w_bcast;
    logic               w_is_read;
    logic               w_idle;
    logic               w_fifo_take;
    logic               w_pop;
    logic               w_tmo_hit;
    logic               w_deq;
    logic               w_space;
    logic               w_push;
    logic               w_drop;
    logic               w_local_wr;
    logic               w_local_rd;
    logic [DW-1:0]      w_reply_data;
    logic [EW-1:0]      w_push_entry;
    logic [EW-1:0]      w_head;

    // Own id wins over the broadcast id when the two are configured equal.
    assign w_local   = (cmdr_dev == dev_id);
    assign w_bcast   = !w_local && (cmdr_dev == BCAST_ID);
    assign w_is_read = cmdr_addr[7];
    assign w_idle    = (r_state == S_IDLE);

    assign w_empty   = (r_count == '0);
    assign w_full    = r_count[FIFO_AW];
    assign w_pop     = !w_empty && cmdt_rdy;
    assign w_tmo_hit = !w_empty && !cmdt_rdy && pluse_us && (r_tmo_cnt == TMO_LAST);
    assign w_deq     = w_pop || w_tmo_hit;
    assign w_space   = !w_full || w_deq;

    // Every broadcast and forwarded command needs a FIFO slot in its strobe cycle.
    assign w_fifo_take = w_idle && cmdr_vld && !w_local;
    assign w_push      = w_space && (w_fifo_take || (r_state == S_REPLY));
    assign w_drop      = cmdr_vld && (!w_idle || (w_fifo_take && !w_space));
    assign w_local_wr  = w_idle && cmdr_vld && !w_is_read && (w_local || (w_bcast && w_space));
    assign w_local_rd  = w_idle && cmdr_vld && w_is_read && w_local;

    assign w_reply_data = r_hold ? r_q : fx_q;
    assign w_push_entry = (r_state == S_REPLY) ? {dev_id, r_raddr, w_reply_data}
                                               : {cmdr_dev, cmdr_mod, cmdr_addr, cmdr_data};

    assign w_head = w_empty ? '0 : r_mem[r_rptr];
    assign {cmdt_dev, cmdt_mod, cmdt_addr, cmdt_data} = w_head;
    assign cmdt_vld = !w_empty;

    assign fx_wr    = r_fx_wr;
    assign fx_rd    = r_fx_rd;
    assign fx_waddr = r_waddr;
    assign fx_raddr = r_raddr;
    assign fx_data  = r_wdata;
    assign drop_cnt = r_drop;
    assign tx_tmo   = r_tx_tmo;

    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_entry;
        end
    end

    // A timeout discard frees the head slot exactly like a handshake pop.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tx_tmo  <= 1'b0;
        end else begin
            r_tx_tmo <= w_tmo_hit;
            if (w_empty || w_deq) begin
                r_tmo_cnt <= '0;
            end else if (pluse_us && !cmdt_rdy) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
        end
    end

    // Read data is sampled in the first REPLY cycle; a stalled reply keeps that copy.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_fx_wr <= 1'b0;
            r_fx_rd <= 1'b0;
            r_waddr <= '0;
            r_raddr <= '0;
            r_wdata <= '0;
            r_q     <= '0;
            r_hold  <= 1'b0;
            r_lat   <= '0;
            r_drop  <= '0;
        end else begin
            r_fx_wr <= 1'b0;
            r_fx_rd <= 1'b0;
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_local_wr) begin
                        r_state <= S_WRITE;
                        r_fx_wr <= 1'b1;
                        r_waddr <= {cmdr_mod, cmdr_addr};
                        r_wdata <= cmdr_data;
                    end else if (w_local_rd) begin
                        r_state <= S_RD_WAIT;
                        r_fx_rd <= 1'b1;
                        r_raddr <= {cmdr_mod, cmdr_addr};
                        r_lat   <= 3'd1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_IDLE;
                end
                S_RD_WAIT: begin
                    if (r_lat == LAT_LAST) begin
                        r_state <= S_REPLY;
                    end else begin
                        r_lat <= r_lat + 3'd1;
                    end
                end
                S_REPLY: begin
                    if (w_push) begin
                        r_state <= S_IDLE;
                        r_hold  <= 1'b0;
                    end else if (!r_hold) begin
                        r_q    <= fx_q;
                        r_hold <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
